// File: rtl/int_pkg.sv
// Shared constants and FSM state encoding for the interrupt controller.
package int_pkg;

  localparam int unsigned N_IRQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRE    = 2'b01,
    SERVICE = 2'b10
  } state_e;

  localparam logic [N_IRQ-1:0] MASK_RST = '0;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-channel synchroniser chain plus history flop; edge_o is high for one
// cycle when the synchronised request goes from low to high.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt request controller: edge-detected pending latch, enable mask,
// fixed-priority arbitration and a single-level IDLE/FIRE/SERVICE sequencer.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned N_IRQ       = int_pkg::N_IRQ,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             we_mask,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             reti,
  output logic             ie1,
  output logic             ie2,
  output logic             ie3,
  output logic             ie4,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] ie_q, ie_d;
  logic [N_IRQ-1:0] cand, win, clr;
  logic             found;
  state_e           state_q, state_d;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .irq_i  (irq[g]),
      .edge_o (rise[g])
    );
  end

  always_comb begin
    cand  = pending_q & mask_q;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (cand[i] && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end

    state_d = state_q;
    ie_d    = '0;
    clr     = '0;
    // Decision uses the currently registered mask; a coincident write lands next cycle.
    mask_d  = we_mask ? mask_in : mask_q;

    case (state_q)
      IDLE: begin
        if (cand != '0) begin
          state_d = FIRE;
          ie_d    = win;
          clr     = win;
        end
      end
      FIRE:    state_d = SERVICE;
      SERVICE: if (reti) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new edge on the channel being issued keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      ie_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ie_q      <= ie_d;
    end
  end

  assign ie1        = ie_q[0];
  assign ie2        = ie_q[1];
  assign ie3        = ie_q[2];
  assign ie4        = ie_q[3];
  assign in_service = (state_q == FIRE) || (state_q == SERVICE);
  assign pending    = pending_q;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt request controller that sits directly upstream of the single-cycle datapath's interrupt inputs. It synchronises four asynchronous peripheral request lines and detects their rising edges. It latches pending requests, applies a CPU-written enable mask, and arbitrates by fixed priority. It drives exactly one of `ie1..ie4` for a single clock, which redirects the PC to the vector and pushes the return address. It then blocks further interrupts until the control unit signals return-from-interrupt.

## Interface
- `N_IRQ`, 4: number of request channels. Fixed at 4, matching `ie1..ie4`; a parameter only for the package constant.
- `SYNC_STAGES`, 2: synchroniser depth per request line. Must be ≥2.
- `clk` input 1: single system clock, rising-edge.
- `reset` input 1: synchronous, active-high. One clock, synchronous reset, active-high (fixed).
- `irq` input 4: asynchronous peripheral requests. Bit 0 maps to `ie1` and has the highest priority.
- `we_mask` input 1: write strobe for the enable mask from the control unit.
- `mask_in` input 4: new enable mask value; bit=1 enables the channel.
- `reti` input 1: return-from-interrupt strobe. Asserted by the control unit in the `pop` cycle of the return instruction.
- `ie1`, `ie2`, `ie3`, `ie4` output 1 each: one-hot, single-cycle interrupt entry pulses.
- `in_service` output 1: high from the `ie` pulse until `reti` is accepted.
- `pending` output 4: latched, not-yet-serviced requests. Debug/status only.

## Operation
- Synchronisation: each `irq[i]` passes through `SYNC_STAGES` flops, then one history flop. `edge[i]` = synced & ~history.
- Pending: `pending[i]` is set on `edge[i]`. It is cleared on the clock edge where channel i is issued. If set and clear coincide on the same bit, set wins; the bit stays pending.
- Mask: `mask` is a 4-bit register, reset value 4'b0000 (all disabled). It is loaded from `mask_in` when `we_mask`=1. Masked requests still latch in `pending` and fire once enabled.
- Candidate: `cand` = `pending` & `mask`. Winner = lowest set index of `cand`.
- FSM states and transitions:
  - IDLE: if `cand`≠0, go to FIRE. Latch the winner one-hot into `ie_q` and clear its pending bit.
  - FIRE: `ie_q` drives `ie1..ie4` for this cycle only. Always go to SERVICE next; `ie_q` returns to 0.
  - SERVICE: stay until `reti`=1, then go to IDLE.
  - `reti` in IDLE or FIRE is ignored. There is no nesting.
- `in_service` = (state==FIRE) | (state==SERVICE).
- A `we_mask` write that coincides with a decision in IDLE uses the old mask for that decision. The new mask applies from the following cycle.
- Reset (any state, any cycle): state=IDLE, `pending`=0, `mask`=0, synchroniser and history flops=0, all `ie*`=0, `in_service`=0.
- Reset mid-SERVICE abandons the interrupt; no `reti` is required afterwards.
- An `irq` held high produces exactly one pending set. Re-triggering requires a low-then-high transition.

## Timing
- Reset values of all outputs are 0.
- `irq` rising before clock edge E0 sets `pending` after edge E0+`SYNC_STAGES` (E2 with defaults).
- If enabled and IDLE, `ie` is high in the cycle following edge E3. The default `irq`-to-`ie` latency is 3 edges.
- An `ie` pulse is exactly one cycle wide. At most one `ie*` is high in any cycle.
- If `reti` is sampled at edge R, state is IDLE after R. The earliest next `ie` is the cycle after edge R+1.
- A pending request arriving during SERVICE is held and issued after `reti`, following the same rule.

## Structure
- Package `int_pkg` holds:
  - `N_IRQ`;
  - state encoding: IDLE=2'b00, FIRE=2'b01, SERVICE=2'b10;
  - the mask reset constant.
- Sub-module `irq_sync_edge`: per-channel synchroniser plus history flop, producing the one-cycle `edge` output. It is instantiated four times.
- The top level holds the pending/mask registers, the priority encoder, and the FSM.

## Test plan
- Reset, then `mask_in`=4'b1111 with `we_mask`; pulse `irq[2]` high for 5 cycles. Expect:
  - `pending`=4'b0100 after 2 edges;
  - `ie3` high for exactly one cycle, 3 edges after `irq` rose;
  - `in_service`=1 until `reti`.
- `irq[3]` and `irq[0]` rise in the same cycle, mask all enabled. Expect:
  - `ie1` first;
  - `pending`=4'b1000 held through SERVICE;
  - after `reti` at edge R, `ie4` in the cycle after R+1.
- Mask=4'b0000, raise `irq[1]`. Expect `pending`=4'b0010 and no `ie` for 20 cycles. Write mask 4'b0010: expect `ie2` one cycle after the write takes effect.
- Hold `irq[0]` high for 30 cycles and issue `reti` after the first `ie1`. Expect exactly one `ie1` pulse in total.
- Assert `reset` during SERVICE with `pending`=4'b0110. Expect after that edge: all outputs 0, `pending`=0, `mask`=0, and no `ie` afterwards even with `irq` still high.
- `reti` in IDLE, and `irq[1]` rising in the same edge as an `ie2` issue. Expect:
  - the `reti` is ignored (state unchanged);
  - `pending[1]` is re-set and fires again after the next `reti`.
